// File: rtl/rcn_master_arb_pkg.sv
// ---------------------------------------------------------------------------
// rcn_master_arb_pkg: ring vector layout, width and packing helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rcn_master_arb_pkg;

  localparam int RCN_W       = 67;
  localparam int RCN_VALID   = 66;
  localparam int RCN_PEND    = 65;
  localparam int RCN_WR      = 64;
  localparam int RCN_ID_HI   = 63;
  localparam int RCN_ID_LO   = 58;
  localparam int RCN_SEQ_HI  = 57;
  localparam int RCN_SEQ_LO  = 56;
  localparam int RCN_MASK_HI = 55;
  localparam int RCN_MASK_LO = 52;
  localparam int RCN_ADDR_HI = 51;
  localparam int RCN_ADDR_LO = 32;
  localparam int RCN_DATA_HI = 31;
  localparam int RCN_DATA_LO = 0;

  typedef struct packed {
    logic        valid;
    logic        pending;
    logic        wr;
    logic [5:0]  id;
    logic [1:0]  seq;
    logic [3:0]  mask;
    logic [19:0] addr;
    logic [31:0] data;
  } rcn_t;

  function automatic logic [RCN_W-1:0] rcn_pack(
    input logic        valid,
    input logic        pending,
    input logic        wr,
    input logic [5:0]  id,
    input logic [1:0]  seq,
    input logic [3:0]  mask,
    input logic [19:0] addr,
    input logic [31:0] data
  );
    logic [RCN_W-1:0] v;
    v                          = '0;
    v[RCN_VALID]               = valid;
    v[RCN_PEND]                = pending;
    v[RCN_WR]                  = wr;
    v[RCN_ID_HI:RCN_ID_LO]     = id;
    v[RCN_SEQ_HI:RCN_SEQ_LO]   = seq;
    v[RCN_MASK_HI:RCN_MASK_LO] = mask;
    v[RCN_ADDR_HI:RCN_ADDR_LO] = addr;
    v[RCN_DATA_HI:RCN_DATA_LO] = data;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rcn_master_arb_if.sv
// ---------------------------------------------------------------------------
// rcn_master_arb_if: requester command / response bundle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rcn_master_arb_if;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [7:0]  mask;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [1:0]  rsp_vld;
  logic        rsp_wr;
  logic [31:0] rsp_data;

  modport master (
    output req, wr, mask, addr, wdata,
    input  ack, rsp_vld, rsp_wr, rsp_data
  );

  modport slave (
    input  req, wr, mask, addr, wdata,
    output ack, rsp_vld, rsp_wr, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/rcn_rr_arb2.sv
// ---------------------------------------------------------------------------
// rcn_rr_arb2: two-way round-robin grant, history moves only on advance. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcn_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = requester 1 won the most recent insertion
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rcn_master_arb.sv
// ---------------------------------------------------------------------------
// rcn_master_arb: ring master stage inserting requests from two ports. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcn_master_arb
  import rcn_master_arb_pkg::*;
#(
  parameter logic [5:0] MASTER_ID = 6'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RCN_W-1:0] rcn_in,
  output logic [RCN_W-1:0] rcn_out,
  rcn_master_arb_if.slave  bus
);

  rcn_t             rin;
  logic [1:0]       next_seq;
  logic [3:0]       outstanding;
  logic [3:0]       owner;
  logic [1:0]       gnt;
  logic [1:0]       ack;
  logic             own_rsp;
  logic             slot_free;
  logic             insert;
  logic             sel;
  logic [RCN_W-1:0] ins_vec;
  logic [1:0]       rsp_vld;
  logic             rsp_wr;
  logic [31:0]      rsp_data;

  rcn_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .advance (insert),
    .gnt     (gnt)
  );

  // Blocking uses the registered outstanding bit, so a seq freed this cycle
  // can only be reused on the following one.
  always_comb begin
    own_rsp   = rin.valid && !rin.pending && (rin.id == MASTER_ID);
    slot_free = !rin.valid || own_rsp;
    insert    = !rst && slot_free && (|bus.req) && !outstanding[next_seq];
    sel       = gnt[1];
    ins_vec   = rcn_pack(1'b1, 1'b1, bus.wr[sel], MASTER_ID, next_seq,
                         sel ? bus.mask[7:4]   : bus.mask[3:0],
                         sel ? bus.addr[39:20] : bus.addr[19:0],
                         sel ? bus.wdata[63:32] : bus.wdata[31:0]);
    ack       = insert ? gnt : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rin         <= '0;
      rcn_out     <= '0;
      rsp_vld     <= 2'b00;
      rsp_wr      <= 1'b0;
      rsp_data    <= '0;
      next_seq    <= 2'd0;
      outstanding <= 4'b0000;
      owner       <= 4'b0000;
    end else begin
      rin <= rcn_t'(rcn_in);

      if (insert) begin
        rcn_out <= ins_vec;
      end else if (own_rsp) begin
        rcn_out <= '0;
      end else begin
        rcn_out <= rin;
      end

      rsp_vld <= 2'b00;
      if (own_rsp && outstanding[rin.seq]) begin
        outstanding[rin.seq] <= 1'b0;
        rsp_vld              <= owner[rin.seq] ? 2'b10 : 2'b01;
        rsp_data             <= rin.data;
        rsp_wr               <= rin.wr;
      end

      // Never collides with the clear above: insertion needs the bit at 0.
      if (insert) begin
        outstanding[next_seq] <= 1'b1;
        owner[next_seq]       <= sel;
        next_seq              <= next_seq + 2'd1;
      end
    end
  end

  assign bus.ack      = ack;
  assign bus.rsp_vld  = rsp_vld;
  assign bus.rsp_wr   = rsp_wr;
  assign bus.rsp_data = rsp_data;

endmodule

`default_nettype wire
